// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage-register enables and bubble flushes for load-use,
// D-cache miss, taken-branch squash, fetch miss and halt. Define HAZARD_CTRL_STATS_EN for stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_wsel,
    input  logic       exm_branch_taken,
    input  logic       exm_dreq,
    input  logic       dhit,
    input  logic       ihit,
    input  logic       mwb_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exm_en,
    output logic       mwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exm_flush,
    output logic       halted
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        SQUASH   = 2'd2,
        HALTED   = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exm_en;
        logic mwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exm_flush;
        logic halted;
    } ctrl_t;

    // Canonical control words, field order as in ctrl_t.
    localparam ctrl_t CTRL_GO         = 9'b11111_000_0;
    localparam ctrl_t CTRL_FREEZE     = 9'b00000_000_0;
    localparam ctrl_t CTRL_HALT       = 9'b00000_000_1;
    localparam ctrl_t CTRL_RESET      = 9'b00000_111_0;
    localparam ctrl_t CTRL_LOAD_USE   = 9'b00111_010_0;
    localparam ctrl_t CTRL_FETCH_MISS = 9'b01111_100_0;
    localparam ctrl_t CTRL_SQUASH     = 9'b11111_111_0;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   load_use;
    logic   dmiss;

    // A load into r0 never creates a real dependency.
    assign load_use = idex_memread && (idex_wsel != 5'd0) &&
                      ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));
    assign dmiss    = exm_dreq && !dhit;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        ctrl    = CTRL_GO;
        state_d = state_q;
        if (RST) begin
            ctrl    = CTRL_RESET;
            state_d = RUN;
        end else if (state_q == HALTED || mwb_halt) begin
            ctrl    = CTRL_HALT;
            state_d = HALTED;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmiss) begin
                        ctrl    = CTRL_FREEZE;
                        state_d = MEM_WAIT;
                    end else if (exm_branch_taken) begin
                        ctrl    = CTRL_SQUASH;
                        state_d = SQUASH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end else if (!ihit) begin
                        ctrl = CTRL_FETCH_MISS;
                    end
                end
                MEM_WAIT: begin
                    if (!dhit) begin
                        ctrl = CTRL_FREEZE;
                    end else if (exm_branch_taken) begin
                        ctrl    = CTRL_SQUASH;
                        state_d = SQUASH;
                    end else begin
                        state_d = RUN;
                    end
                end
                SQUASH: begin
                    // ID holds the bubble inserted last cycle, so load-use cannot apply.
                    state_d = RUN;
                    if (!ihit) begin
                        ctrl = CTRL_FETCH_MISS;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exm_en     = ctrl.exm_en;
    assign mwb_en     = ctrl.mwb_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign exm_flush  = ctrl.exm_flush;
    assign halted     = ctrl.halted;

`ifdef HAZARD_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate; the halt cycles are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_en && !ctrl.halted && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ctrl.exm_flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // Expected control words: {pc,ifid,idex,exm,mwb enables, ifid,idex,exm flushes, halted}
    localparam logic [8:0] V_GO   = 9'b11111_000_0;
    localparam logic [8:0] V_FRZ  = 9'b00000_000_0;
    localparam logic [8:0] V_HALT = 9'b00000_000_1;
    localparam logic [8:0] V_RST  = 9'b00000_111_0;
    localparam logic [8:0] V_LU   = 9'b00111_010_0;
    localparam logic [8:0] V_FM   = 9'b01111_100_0;
    localparam logic [8:0] V_BR   = 9'b11111_111_0;

    logic       CLK;
    logic       RST;
    logic [4:0] ifid_rs, ifid_rt, idex_wsel;
    logic       ifid_uses_rt, idex_memread, exm_branch_taken, exm_dreq, dhit, ihit, mwb_halt;
    logic       pc_en, ifid_en, idex_en, exm_en, mwb_en;
    logic       ifid_flush, idex_flush, exm_flush, halted;
`ifdef HAZARD_CTRL_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif
    logic [8:0] obs;

    int vecs = 0;
    int miss = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ifid_rs          (ifid_rs),
        .ifid_rt          (ifid_rt),
        .ifid_uses_rt     (ifid_uses_rt),
        .idex_memread     (idex_memread),
        .idex_wsel        (idex_wsel),
        .exm_branch_taken (exm_branch_taken),
        .exm_dreq         (exm_dreq),
        .dhit             (dhit),
        .ihit             (ihit),
        .mwb_halt         (mwb_halt),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exm_en           (exm_en),
        .mwb_en           (mwb_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exm_flush        (exm_flush),
        .halted           (halted)
`ifdef HAZARD_CTRL_STATS_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    assign obs = {pc_en, ifid_en, idex_en, exm_en, mwb_en, ifid_flush, idex_flush, exm_flush, halted};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Benign inputs: no hazards, fetch completes.
    task automatic idle();
        RST = 1'b0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
        idex_memread = 1'b0; idex_wsel = 5'd0; exm_branch_taken = 1'b0;
        exm_dreq = 1'b0; dhit = 1'b0; ihit = 1'b1; mwb_halt = 1'b0;
    endtask

    // Start of a cycle: inputs change on the falling edge, outputs are read 1 ns later.
    task automatic next_cycle();
        @(negedge CLK);
        idle();
    endtask

    task automatic set_load_use(input logic [4:0] r);
        idex_memread = 1'b1; idex_wsel = r; ifid_rs = r;
    endtask

    task automatic test_reset();
        next_cycle();
        RST = 1'b1; exm_branch_taken = 1'b1; exm_dreq = 1'b1; mwb_halt = 1'b1;
        #1;
        vecs++;
        if (obs !== V_RST) begin miss++; $display("FAIL reset_outputs got %b exp %b", obs, V_RST); end
        next_cycle();
        #1;
        vecs++;
        if (obs !== V_GO) begin miss++; $display("FAIL after_reset_idle got %b exp %b", obs, V_GO); end
`ifdef HAZARD_CTRL_STATS_EN
        vecs++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            miss++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        logic [8:0] exp_q[$];
        // Stimulus per cycle: {memread, wsel, rs, rt, uses_rt, ihit}
        logic [17:0] stim[$];
        stim = '{{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1},   // load r5, add reads r5
                 {1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1},   // load moved on
                 {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1},   // load to r0 never stalls
                 {1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1},   // rt dependency
                 {1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1},   // rt not read
                 {1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b1},   // persists: stall again
                 {1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b1},
                 {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}};  // fetch miss
        exp_q = '{V_LU, V_GO, V_GO, V_LU, V_GO, V_LU, V_LU, V_FM};
        for (int i = 0; i < stim.size(); i++) begin
            next_cycle();
            {idex_memread, idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt, ihit} = stim[i];
            #1;
            vecs++;
            if (obs !== exp_q[i]) begin
                miss++; $display("FAIL load_use[%0d] got %b exp %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [8:0] e;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            case (i)
                0: begin exm_dreq = 1'b1; exm_branch_taken = 1'b1; e = V_FRZ; end
                1: begin exm_dreq = 1'b1; e = V_FRZ; end
                2: begin exm_dreq = 1'b1; set_load_use(5'd4); e = V_FRZ; end
                3: begin exm_dreq = 1'b1; dhit = 1'b1; set_load_use(5'd4); e = V_GO; end
                4: begin set_load_use(5'd4); e = V_LU; end
                5: begin exm_dreq = 1'b1; e = V_FRZ; end
                6: begin exm_dreq = 1'b1; dhit = 1'b1; exm_branch_taken = 1'b1; e = V_BR; end
                default: begin set_load_use(5'd2); e = V_GO; end
            endcase
            #1;
            vecs++;
            if (obs !== e) begin miss++; $display("FAIL mem_wait[%0d] got %b exp %b", i, obs, e); end
        end
    endtask

    task automatic test_branch();
        logic [8:0] e;
        test_reset();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            case (i)
                0: begin exm_branch_taken = 1'b1; set_load_use(5'd6); e = V_BR; end
                1: begin set_load_use(5'd6); e = V_GO; end
                2: begin exm_branch_taken = 1'b1; e = V_BR; end
                3: begin ihit = 1'b0; set_load_use(5'd6); e = V_FM; end
                4: begin set_load_use(5'd6); e = V_LU; end
                default: e = V_GO;
            endcase
            #1;
            vecs++;
            if (obs !== e) begin miss++; $display("FAIL branch[%0d] got %b exp %b", i, obs, e); end
`ifdef HAZARD_CTRL_STATS_EN
            if (i == 1) begin
                vecs++;
                if (flush_cnt !== CW'(1)) begin miss++; $display("FAIL flush_cnt_1 got %0d exp 1", flush_cnt); end
            end
            if (i == 5) begin
                vecs++;
                if (stall_cnt !== CW'(2) || flush_cnt !== CW'(2)) begin
                    miss++; $display("FAIL branch_counters got %0d/%0d exp 2/2", stall_cnt, flush_cnt);
                end
            end
`endif
        end
    endtask

    task automatic test_halt();
        logic [8:0] e;
        test_reset();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 0) begin
                mwb_halt = 1'b1; exm_branch_taken = 1'b1; exm_dreq = 1'b1; e = V_HALT;
            end else if (i < 4) begin
                exm_branch_taken = 1'($urandom); exm_dreq = 1'($urandom); dhit = 1'($urandom);
                ihit = 1'($urandom); set_load_use(5'($urandom_range(1, 31))); e = V_HALT;
            end else if (i == 4) begin
                RST = 1'b1; e = V_RST;
            end else begin
                e = V_GO;
            end
            #1;
            vecs++;
            if (obs !== e) begin miss++; $display("FAIL halt[%0d] got %b exp %b", i, obs, e); end
`ifdef HAZARD_CTRL_STATS_EN
            if (i == 4) begin
                vecs++;
                if (stall_cnt !== '0 || flush_cnt !== '0) begin
                    miss++; $display("FAIL halt_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mem_wait();
        logic [8:0] e;
        test_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            case (i)
                0: begin ihit = 1'b0; e = V_FM; end
                1: begin exm_dreq = 1'b1; e = V_FRZ; end
                2: begin exm_dreq = 1'b1; e = V_FRZ; end
                3: begin RST = 1'b1; exm_dreq = 1'b1; e = V_RST; end
                default: e = V_GO;
            endcase
            #1;
            vecs++;
            if (obs !== e) begin miss++; $display("FAIL reset_mem_wait[%0d] got %b exp %b", i, obs, e); end
`ifdef HAZARD_CTRL_STATS_EN
            if (i == 3 || i == 4) begin
                vecs++;
                if (stall_cnt !== CW'(i == 3 ? 3 : 0) || flush_cnt !== '0) begin
                    miss++; $display("FAIL reset_mem_wait_cnt[%0d] got %0d/%0d exp %0d/0",
                                     i, stall_cnt, flush_cnt, (i == 3 ? 3 : 0));
                end
            end
`endif
        end
    endtask

    // Randomized traffic against a model built from the controller's rules.
    task automatic test_random();
        bit         waiting, squashed, stopped;
        int         stalls, flushes;
        bit         hazard, is_stall;
        logic [8:0] e;
        int         srcs[$];
        test_reset();
        waiting = 0; squashed = 0; stopped = 0; stalls = 0; flushes = 0;
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            RST              = ($urandom_range(0, 31) == 0);
            ifid_rs          = 5'($urandom_range(0, 3));
            ifid_rt          = 5'($urandom_range(0, 3));
            ifid_uses_rt     = 1'($urandom);
            idex_memread     = 1'($urandom);
            idex_wsel        = 5'($urandom_range(0, 3));
            exm_branch_taken = ($urandom_range(0, 5) == 0);
            exm_dreq         = ($urandom_range(0, 2) == 0);
            dhit             = 1'($urandom);
            ihit             = ($urandom_range(0, 3) != 0);
            mwb_halt         = ($urandom_range(0, 63) == 0);
            #1;
            srcs = {int'(ifid_rs)};
            if (ifid_uses_rt) srcs.push_back(int'(ifid_rt));
            hazard = idex_memread && idex_wsel != 0 &&
                     (srcs.find_first_index(x) with (x == int'(idex_wsel))).size() != 0;

            if (RST)                                        e = V_RST;
            else if (stopped || mwb_halt)                   e = V_HALT;
            else if (waiting && !dhit)                      e = V_FRZ;
            else if (!waiting && !squashed && exm_dreq && !dhit) e = V_FRZ;
            else if (!squashed && exm_branch_taken)         e = V_BR;
            else if (waiting)                               e = V_GO;
            else if (!squashed && hazard)                   e = V_LU;
            else if (!ihit)                                 e = V_FM;
            else                                            e = V_GO;

            vecs++;
            if (obs !== e) begin
                miss++; $display("FAIL random[%0d] got %b exp %b (wait=%0d sq=%0d halt=%0d)",
                                 n, obs, e, waiting, squashed, stopped);
            end
`ifdef HAZARD_CTRL_STATS_EN
            vecs++;
            if (int'(stall_cnt) != stalls || int'(flush_cnt) != flushes) begin
                miss++; $display("FAIL random_cnt[%0d] got %0d/%0d exp %0d/%0d",
                                 n, stall_cnt, flush_cnt, stalls, flushes);
            end
`endif
            // Advance the model to what the next rising edge commits.
            is_stall = (e[8] == 1'b0) && (e[0] == 1'b0);
            if (RST) begin
                waiting = 0; squashed = 0; stopped = 0; stalls = 0; flushes = 0;
            end else begin
                if (is_stall && stalls < CNT_MAX) stalls++;
                if (e == V_BR && flushes < CNT_MAX) flushes++;
                stopped  = (e == V_HALT);
                waiting  = (e == V_FRZ);
                squashed = (e == V_BR);
            end
        end
    endtask

    initial begin
        idle();
        RST = 1'b1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_halt();
        test_reset_mem_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
